// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch (IF) stage and IF/ID pipeline register.
//
// Keeps the fetch PC, presents it to instruction memory and registers the
// returned word with its PC and PC+4 for decode. A redirect from execute
// always wins. Flushes and memory wait cycles load a NOP bubble into IF/ID,
// and every bubble is counted.
//
// Ports:
//   clk          - single clock; all state updates on its rising edge
//   reset        - synchronous active-high reset
//   StallF       - hold the fetch PC
//   StallD       - hold the IF/ID register
//   FlushD       - load a bubble into IF/ID
//   PCSrcE       - taken branch/jump redirect from execute
//   pc_targetE   - redirect target (low two bits forced to zero)
//   imem_addr    - instruction memory address (the fetch PC)
//   imem_rdata   - instruction word, valid when imem_ready=1
//   imem_ready   - memory response valid this cycle
//   instrD       - registered instruction for decode
//   pcD          - registered PC of instrD
//   pc_plus_4D   - registered pcD+4
//   validD       - instrD is a real fetched instruction
//   misalignF    - one-cycle pulse after a redirect to a misaligned target
//   bubble_count - number of edges on which a bubble entered IF/ID
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] pc_targetE,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] instrD,
  output logic [31:0] pcD,
  output logic [31:0] pc_plus_4D,
  output logic        validD,
  output logic        misalignF,
  output logic [31:0] bubble_count
);

  logic [31:0] pc_p0;
  logic [31:0] pc_plus_4_p0;
  logic [31:0] pc_next_p0;
  logic        load_bubble_p0;
  logic        load_instr_p0;

  assign imem_addr    = pc_p0;
  assign pc_plus_4_p0 = pc_p0 + 32'd4;  // wraps modulo 2^32

  // Redirect has top priority so it is never lost under a stall.
  always_comb begin
    pc_next_p0 = pc_plus_4_p0;
    if (PCSrcE)
      pc_next_p0 = {pc_targetE[31:2], 2'b00};
    else if (StallF || !imem_ready)
      pc_next_p0 = pc_p0;
  end

  // Flush/redirect beats stall; a memory wait only bubbles when not stalled.
  always_comb begin
    load_bubble_p0 = 1'b0;
    load_instr_p0  = 1'b0;
    if (FlushD || PCSrcE)
      load_bubble_p0 = 1'b1;
    else if (!StallD) begin
      if (!imem_ready)
        load_bubble_p0 = 1'b1;
      else
        load_instr_p0 = 1'b1;
    end
  end

  // ---- IF -> ID boundary ----
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_p0        <= RESET_PC;
      instrD       <= NOP_INSTR;
      pcD          <= 32'd0;
      pc_plus_4D   <= 32'd0;
      validD       <= 1'b0;
      misalignF    <= 1'b0;
      bubble_count <= 32'd0;
    end else begin
      pc_p0     <= pc_next_p0;
      misalignF <= PCSrcE && (pc_targetE[1:0] != 2'b00);
      if (load_bubble_p0) begin
        instrD       <= NOP_INSTR;
        pcD          <= 32'd0;
        pc_plus_4D   <= 32'd0;
        validD       <= 1'b0;
        bubble_count <= bubble_count + 32'd1;
      end else if (load_instr_p0) begin
        instrD     <= imem_rdata;
        pcD        <= pc_p0;
        pc_plus_4D <= pc_plus_4_p0;
        validD     <= 1'b1;
      end
    end
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h0000_0000, the PC value loaded on reset.
REQ-002 SHALL provide parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0), the bubble encoding.
REQ-003 SHALL have port clk, input, 1, the single clock, with all state updated on the rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port StallF, input, 1, which holds the PC.
REQ-006 SHALL have port StallD, input, 1, which holds the IF/ID register.
REQ-007 SHALL have port FlushD, input, 1, which loads a bubble into IF/ID.
REQ-008 SHALL have port PCSrcE, input, 1, the taken-branch/jump redirect from execute.
REQ-009 SHALL have port pc_targetE, input, 32, the redirect target.
REQ-010 SHALL have port imem_addr, output, 32, the instruction memory address.
REQ-011 SHALL have port imem_rdata, input, 32, the instruction word, valid when imem_ready=1.
REQ-012 SHALL have port imem_ready, input, 1, memory response valid this cycle.
REQ-013 SHALL have port instrD, output, 32, the registered instruction to decode.
REQ-014 SHALL have port pcD, output, 32, the registered PC of instrD.
REQ-015 SHALL have port pc_plus_4D, output, 32, the registered pcD+4.
REQ-016 SHALL have port validD, output, 1, which is 1 when instrD is a real fetched instruction.
REQ-017 SHALL have port misalignF, output, 1, a one-cycle pulse marking a redirect target with [1:0]!=0.
REQ-018 SHALL have port bubble_count, output, 32, counting the cycles in which a bubble was loaded into IF/ID.

Function
REQ-019 SHALL drive imem_addr = pcF combinationally, with pcF being the internal PC register.
REQ-020 SHALL select the next pcF in priority order: PCSrcE -> {pc_targetE[31:2],2'b00}; else StallF or !imem_ready -> hold; else pcF+4.
REQ-021 SHALL compute pcF+4 and pc_plus_4D modulo 2^32, so 32'hFFFF_FFFC+4 = 0.
REQ-022 SHALL let PCSrcE override StallF in the same cycle; the redirect is never lost.
REQ-023 SHALL pulse misalignF high in the cycle after PCSrcE=1 with pc_targetE[1:0]!=0, and hold it 0 otherwise.
REQ-024 SHALL update IF/ID with priority FlushD or PCSrcE -> bubble; else StallD -> hold; else !imem_ready -> bubble; else load {imem_rdata, pcF, pcF+4, validD=1}.
REQ-025 SHALL define a bubble as instrD=NOP_INSTR, pcD=0, pc_plus_4D=0, validD=0.
REQ-026 SHALL let flush beat stall when StallD and FlushD are both 1.
REQ-027 SHALL NOT advance pcF when StallD=0, StallF=0 and imem_ready=0; the same address is re-presented until imem_ready=1.
REQ-028 SHALL increment bubble_count by 1 on every edge where a bubble is loaded (REQ-024), not while holding, wrapping at 2^32.
REQ-029 SHALL have a fetch-to-decode latency of 1 cycle: a word accepted at edge N appears on instrD after edge N.

Reset
REQ-030 SHALL, on reset=1 at a clock edge, set pcF=RESET_PC, instrD=NOP_INSTR, pcD=0, pc_plus_4D=0, validD=0, misalignF=0 and bubble_count=0, overriding all other inputs.
REQ-031 SHALL, on reset asserted mid-stall or mid-redirect, discard the pending state; the first fetch after release is at RESET_PC.
REQ-032 SHALL NOT count reset-loaded bubbles in bubble_count.

Verification
REQ-033 SHALL cover reset release with imem_ready=1 and sequential words -> imem_addr 0,4,8 on consecutive cycles; instrD/pcD follow 1 cycle later with validD=1.
REQ-034 SHALL cover PCSrcE=1 with pc_targetE=32'h100 and StallF=1 -> next imem_addr=32'h100; instrD=NOP_INSTR with validD=0; bubble_count +1.
REQ-035 SHALL cover imem_ready=0 for 3 cycles at pcF=32'h20 -> imem_addr held at 32'h20; 3 bubbles with bubble_count +3; then the word at 32'h20 is delivered with validD=1.
REQ-036 SHALL cover StallD=1 and StallF=1 for 2 cycles -> instrD, pcD and pcF unchanged, bubble_count unchanged; StallD=1 with FlushD=1 -> bubble.
REQ-037 SHALL cover pc_targetE=32'h0000_0106 -> pcF=32'h104 and misalignF high for exactly 1 cycle.
REQ-038 SHALL cover pcF=32'hFFFF_FFFC with imem_ready=1 -> next pcF=0 and pc_plus_4D=0.
